// File: rtl/tl_ca_merge_arb.sv
// ---------------------------------------------------------------------------
// tl_ca_merge_arb
//   Merges a TileLink master's A channel and C channel (ProbeAck / Release
//   traffic) onto one downstream A channel. Arbitration is burst-aware: once
//   the first beat of a multi-beat message is accepted, the grant stays on
//   that channel until its last beat. The merged beat sits in a single output
//   register (oreg). The D channel is passed straight through.
//
// Parameters
//   ARB_MODE      0: A fixed priority with C starvation guard, 1: round-robin
//   C_STARVE_MAX  A messages allowed while C waits before C is forced (1..15)
//   BUS_BYTES     bytes per beat
//   MAX_SIZE      largest legal log2 message size
//
// Ports
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   in     upstream A, C and D channels (TL_BUS.Master)
//   out    downstream A and D channels   (TL_BUS.Slave)
// ---------------------------------------------------------------------------

package tl_pkg;
    parameter int MASK_WTH = 8;
    parameter int DATA_W   = 8 * MASK_WTH;
    parameter int ADDR_W   = 32;
    parameter int SRC_W    = 4;
    parameter int SINK_W   = 2;
    parameter int SIZE_W   = 4;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SRC_W-1:0]    source;
        logic [ADDR_W-1:0]   address;
        logic [MASK_WTH-1:0] mask;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SRC_W-1:0]    source;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } tl_c_t;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [1:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SRC_W-1:0]    source;
        logic [SINK_W-1:0]   sink;
        logic                denied;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } tl_d_t;
endpackage

interface TL_BUS;
    logic          a_valid;
    logic          a_ready;
    tl_pkg::tl_a_t a_bits;
    logic          c_valid;
    logic          c_ready;
    tl_pkg::tl_c_t c_bits;
    logic          d_valid;
    logic          d_ready;
    tl_pkg::tl_d_t d_bits;

    // Side facing the upstream master (the block receives A/C, returns D).
    modport Master (
        input  a_valid, a_bits, c_valid, c_bits, d_ready,
        output a_ready, c_ready, d_valid, d_bits
    );
    // Side facing the downstream slave (the block sends A, receives D).
    modport Slave (
        output a_valid, a_bits, d_ready,
        input  a_ready, d_valid, d_bits
    );
endinterface

module tl_ca_merge_arb #(
    parameter int ARB_MODE     = 0,
    parameter int C_STARVE_MAX = 4,
    parameter int BUS_BYTES    = tl_pkg::MASK_WTH,
    parameter int MAX_SIZE     = 6
) (
    input  logic  clk_i,
    input  logic  rst_i,
    TL_BUS.Master in,
    TL_BUS.Slave  out
);

    localparam int CNT_W    = $clog2((1 << MAX_SIZE) / BUS_BYTES) + 1;
    localparam int LG_BYTES = $clog2(BUS_BYTES);
    localparam logic [3:0] STARVE_MAX = 4'(C_STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCK_A,
        ST_LOCK_C
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        starve_q;
    logic              ptr_q;          // preferred channel in RR mode: 0 = A, 1 = C
    logic              oreg_valid_q;
    tl_pkg::tl_a_t     oreg_q;

    logic              stage_ready;
    logic              pick_c;
    logic              gnt_a;
    logic              gnt_c;
    logic              acc_a;
    logic              acc_c;
    logic              done_a;
    logic              done_c;
    logic [CNT_W-1:0]  a_m1_d;
    logic [CNT_W-1:0]  c_m1_d;

    // Beats-minus-one of a message, from its first beat only.
    function automatic logic [CNT_W-1:0] beats_m1(input logic [tl_pkg::SIZE_W-1:0] size,
                                                 input logic data_op);
        int unsigned n;
        n = 32'd1;
        if (data_op && (int'(size) > LG_BYTES)) begin
            n = 32'd1 << (int'(size) - LG_BYTES);
        end
        return CNT_W'(n - 32'd1);
    endfunction

    // C beats carry no mask; a full-beat mask is substituted.
    function automatic tl_pkg::tl_a_t c_to_a(input tl_pkg::tl_c_t c);
        tl_pkg::tl_a_t a;
        a.opcode  = c.opcode;
        a.param   = c.param;
        a.size    = c.size;
        a.source  = c.source;
        a.address = c.address;
        a.mask    = '1;
        a.data    = c.data;
        a.corrupt = c.corrupt;
        return a;
    endfunction

    assign stage_ready = !oreg_valid_q || out.a_ready;

    // Data opcodes: A 0..3, C ProbeAckData (5) and ReleaseData (7).
    assign a_m1_d = beats_m1(in.a_bits.size, !in.a_bits.opcode[2]);
    assign c_m1_d = beats_m1(in.c_bits.size, in.c_bits.opcode[2] & in.c_bits.opcode[0]);

    assign pick_c = (ARB_MODE == 0) ? (starve_q == STARVE_MAX) : ptr_q;

    always_comb begin
        gnt_a = 1'b0;
        gnt_c = 1'b0;
        case (state_q)
            ST_LOCK_A: gnt_a = 1'b1;
            ST_LOCK_C: gnt_c = 1'b1;
            default: begin
                if (in.a_valid && in.c_valid) begin
                    gnt_a = !pick_c;
                    gnt_c = pick_c;
                end else if (in.a_valid) begin
                    gnt_a = 1'b1;
                end else if (in.c_valid) begin
                    gnt_c = 1'b1;
                end else begin
                    // Nothing pending: both may see ready; no accept can happen.
                    gnt_a = 1'b1;
                    gnt_c = 1'b1;
                end
            end
        endcase
    end

    assign in.a_ready = gnt_a && stage_ready;
    assign in.c_ready = gnt_c && stage_ready;

    assign acc_a = in.a_valid && in.a_ready;
    assign acc_c = in.c_valid && in.c_ready;

    assign done_a = acc_a && ((state_q == ST_IDLE) ? (a_m1_d == '0) : (cnt_q == '0));
    assign done_c = acc_c && ((state_q == ST_IDLE) ? (c_m1_d == '0) : (cnt_q == '0));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            starve_q     <= '0;
            ptr_q        <= 1'b0;
            oreg_valid_q <= 1'b0;
            oreg_q       <= '0;
        end else begin
            if (acc_a) begin
                oreg_valid_q <= 1'b1;
                oreg_q       <= in.a_bits;
            end else if (acc_c) begin
                oreg_valid_q <= 1'b1;
                oreg_q       <= c_to_a(in.c_bits);
            end else if (out.a_ready) begin
                oreg_valid_q <= 1'b0;
            end

            // The counter holds beats still to come after the current one.
            case (state_q)
                ST_LOCK_A: begin
                    if (acc_a) begin
                        if (cnt_q == '0) state_q <= ST_IDLE;
                        else             cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end
                ST_LOCK_C: begin
                    if (acc_c) begin
                        if (cnt_q == '0) state_q <= ST_IDLE;
                        else             cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    if (acc_a && (a_m1_d != '0)) begin
                        state_q <= ST_LOCK_A;
                        cnt_q   <= a_m1_d - CNT_W'(1);
                    end else if (acc_c && (c_m1_d != '0)) begin
                        state_q <= ST_LOCK_C;
                        cnt_q   <= c_m1_d - CNT_W'(1);
                    end
                end
            endcase

            if (!in.c_valid || done_c) begin
                starve_q <= '0;
            end else if (done_a && (starve_q != STARVE_MAX)) begin
                starve_q <= starve_q + 4'd1;
            end

            if (done_a && !ptr_q) begin
                ptr_q <= 1'b1;
            end else if (done_c && ptr_q) begin
                ptr_q <= 1'b0;
            end
        end
    end

    assign out.a_valid = oreg_valid_q;
    assign out.a_bits  = oreg_q;

    assign in.d_valid  = out.d_valid;
    assign in.d_bits   = out.d_bits;
    assign out.d_ready = in.d_ready;

endmodule
